// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, ALUOp modes and controller state encoding shared by alu_share_ctrl.
package alu_pkg;
    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_AND  = 6'b000011;
    localparam logic [5:0] OP_OR   = 6'b000100;
    localparam logic [5:0] OP_XOR  = 6'b000101;
    localparam logic [5:0] OP_NOT  = 6'b000110;
    localparam logic [5:0] OP_SHL  = 6'b000111;
    localparam logic [5:0] OP_SHR  = 6'b001000;
    localparam logic [5:0] OP_MUL  = 6'b001001;
    localparam logic [5:0] OP_DIV  = 6'b001010;
    localparam logic [5:0] OP_MOD  = 6'b001011;
    localparam logic [5:0] OP_LAST = 6'b001011;
    localparam logic [1:0] AOP_NORM = 2'b00;
    localparam logic [1:0] AOP_IMM  = 2'b01;
    localparam logic [1:0] AOP_BNE  = 2'b10;
    localparam logic [1:0] AOP_IMM4 = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
    function automatic logic is_muldiv(input logic [5:0] op);
        return op == OP_MUL || op == OP_DIV || op == OP_MOD;
    endfunction
endpackage

// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: one requester's request and held-response channels into alu_share_ctrl.
interface alu_share_ctrl_if #(parameter int DATA_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_op;
    logic [1:0]        req_aluop;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_err;
    modport master (
        output req_valid, req_op, req_aluop, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
    modport slave (
        input  req_valid, req_op, req_aluop, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin grant; on contention the requester that did not win last time wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);
    always_comb grant = (&valid) ? (last_grant ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin time-sharing of one combinational ALU between two requesters.
// Define ALU_SHARE_MULTICYCLE_EN to stretch EXEC by MULDIV_LAT cycles for mul/div/mod.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MULDIV_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_ctrl_if.slave   r0,
    alu_share_ctrl_if.slave   r1,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    output logic [5:0]        alu_operation,
    output logic [1:0]        alu_aluop,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);
    state_t                   state_q, state_d;
    logic                     owner_q, owner_d, last_q, last_d;
    logic [DATA_W-1:0]        d1_q, d1_d, d2_q, d2_d;
    logic [5:0]               op_q, op_d;
    logic [1:0]               aop_q, aop_d;
    logic [1:0]               vld_q, vld_d, zero_q, zero_d, err_q, err_d;
    logic [1:0][DATA_W-1:0]   res_q, res_d;
    logic [1:0]               grant, rdy;
    logic [5:0]               sel_op;
    logic                     cap, err;

    rr_arb2 u_arb (.valid({r1.req_valid, r0.req_valid}), .last_grant(last_q), .grant(grant));

    // ready is forced low while reset is held so every output reads 0 immediately
    assign rdy    = (rst_n && state_q == S_IDLE) ? grant : 2'b00;
    assign sel_op = grant[1] ? r1.req_op : r0.req_op;
    assign err    = (op_q > OP_LAST) | ((op_q == OP_DIV | op_q == OP_MOD) & d2_q == '0);

`ifdef ALU_SHARE_MULTICYCLE_EN
    localparam int CNT_W = $clog2(MULDIV_LAT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = cnt_q;
        if (|rdy) cnt_d = is_muldiv(sel_op) ? CNT_W'(MULDIV_LAT) : '0;
        else if (state_q == S_EXEC && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign cap = state_q == S_EXEC && cnt_q == '0;
`else
    assign cap = state_q == S_EXEC;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        op_d    = op_q;
        aop_d   = aop_q;
        vld_d   = vld_q;
        res_d   = res_q;
        zero_d  = zero_q;
        err_d   = err_q;
        if (|rdy) begin
            owner_d = grant[1];
            last_d  = grant[1];
            d1_d    = grant[1] ? r1.req_a : r0.req_a;
            d2_d    = grant[1] ? r1.req_b : r0.req_b;
            op_d    = sel_op;
            aop_d   = grant[1] ? r1.req_aluop : r0.req_aluop;
            state_d = S_EXEC;
        end
        if (cap) begin
            res_d[owner_q]  = (aop_q == AOP_BNE || err) ? '0 : alu_result;
            zero_d[owner_q] = (aop_q == AOP_NORM || aop_q == AOP_BNE) && alu_zero;
            err_d[owner_q]  = err;
            vld_d[owner_q]  = 1'b1;
            state_d         = S_RESP;
        end
        if (state_q == S_RESP && (owner_q ? r1.rsp_ready : r0.rsp_ready)) begin
            vld_d[owner_q] = 1'b0;
            state_d        = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            d1_q    <= '0;
            d2_q    <= '0;
            op_q    <= '0;
            aop_q   <= '0;
            vld_q   <= '0;
            res_q   <= '0;
            zero_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            op_q    <= op_d;
            aop_q   <= aop_d;
            vld_q   <= vld_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign r0.req_ready  = rdy[0];
    assign r1.req_ready  = rdy[1];
    assign r0.rsp_valid  = vld_q[0];
    assign r1.rsp_valid  = vld_q[1];
    assign r0.rsp_result = res_q[0];
    assign r1.rsp_result = res_q[1];
    assign r0.rsp_zero   = zero_q[0];
    assign r1.rsp_zero   = zero_q[1];
    assign r0.rsp_err    = err_q[0];
    assign r1.rsp_err    = err_q[1];
    assign alu_data1     = d1_q;
    assign alu_data2     = d2_q;
    assign alu_operation = op_q;
    assign alu_aluop     = aop_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed stimulus, a transaction-level reference model checked every cycle,
// and literal expectations for the headline cases; stub ALU included.
module tb_alu_share_ctrl;
    localparam int LAT = 4;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        e;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0]       v = '0, rr = 2'b11;
    logic [1:0][5:0]  op = '0;
    logic [1:0][1:0]  aop = '0;
    logic [1:0][31:0] a = '0, b = '0;
    logic [31:0] alu_data1, alu_data2, alu_result;
    logic [5:0]  alu_operation;
    logic [1:0]  alu_aluop;
    logic        alu_zero;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    alu_share_ctrl_if #(.DATA_W(32)) i0 ();
    alu_share_ctrl_if #(.DATA_W(32)) i1 ();

    assign i0.req_valid = v[0];   assign i1.req_valid = v[1];
    assign i0.req_op    = op[0];  assign i1.req_op    = op[1];
    assign i0.req_aluop = aop[0]; assign i1.req_aluop = aop[1];
    assign i0.req_a     = a[0];   assign i1.req_a     = a[1];
    assign i0.req_b     = b[0];   assign i1.req_b     = b[1];
    assign i0.rsp_ready = rr[0];  assign i1.rsp_ready = rr[1];

    wire [1:0]  rdy = {i1.req_ready, i0.req_ready};
    wire [1:0]  rv  = {i1.rsp_valid, i0.rsp_valid};
    wire [1:0]  rz  = {i1.rsp_zero, i0.rsp_zero};
    wire [1:0]  re  = {i1.rsp_err, i0.rsp_err};
    wire [31:0] res0 = i0.rsp_result;
    wire [31:0] res1 = i1.rsp_result;

    alu_share_ctrl #(.DATA_W(32), .MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .r0(i0), .r1(i1),
        .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_operation(alu_operation), .alu_aluop(alu_aluop),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // stand-in for the shared ALU: immediate modes pass data2, BNE flags inequality
    function automatic logic [31:0] alu_fn(input logic [5:0] o, input logic [1:0] m, input logic [31:0] x, input logic [31:0] y);
        if (m[0]) return y;
        case (o)
            6'd0:    return y;
            6'd1:    return x + y;
            6'd2:    return x - y;
            6'd3:    return x & y;
            6'd4:    return x | y;
            6'd5:    return x ^ y;
            6'd6:    return ~x;
            6'd7:    return x << y[4:0];
            6'd8:    return x >> y[4:0];
            6'd9:    return x * y;
            6'd10:   return (y == 0) ? 32'hffff_ffff : x / y;
            6'd11:   return (y == 0) ? x : x % y;
            default: return 32'hdead_beef;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_operation, alu_aluop, alu_data1, alu_data2);
    assign alu_zero   = (alu_aluop == 2'b10) ? (alu_data1 != alu_data2) : (alu_result == 32'd0);

    function automatic rsp_t golden(input logic [5:0] o, input logic [1:0] m, input logic [31:0] x, input logic [31:0] y);
        rsp_t r;
        r.e   = (o > 6'd11) || ((o == 6'd10 || o == 6'd11) && y == 0);
        r.res = (m == 2'b10 || r.e) ? 32'd0 : alu_fn(o, m, x, y);
        r.z   = (m == 2'b00) ? (alu_fn(o, m, x, y) == 0) : (m == 2'b10) ? (x != y) : 1'b0;
        return r;
    endfunction

    function automatic int exec_len(input logic [5:0] o);
`ifdef ALU_SHARE_MULTICYCLE_EN
        return (o == 6'd9 || o == 6'd10 || o == 6'd11) ? 1 + LAT : 1;
`else
        return (o == 6'd63) ? 1 : 1;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: one transaction in flight, response due exec_len cycles after acceptance
    bit          m_busy = 0, m_own = 0, m_last = 1;
    int          m_wait = 0;
    rsp_t        m_rsp = '0;
    logic [31:0] e_d1 = '0, e_d2 = '0;
    logic [5:0]  e_op = '0;
    logic [1:0]  e_aop = '0;

    always @(negedge clk) begin : compare
        logic [1:0] g, ev;
        if (!rst_n) begin
            chk("rst_ctl", {rdy, rv, rz, re, alu_operation, alu_aluop}, 64'd0);
            chk("rst_alu", {alu_data1, alu_data2}, 64'd0);
            chk("rst_res", {res0, res1}, 64'd0);
            m_busy = 0; m_last = 1; m_wait = 0;
            e_d1 = '0; e_d2 = '0; e_op = '0; e_aop = '0;
        end else begin
            g = 2'b00;
            if (!m_busy) begin
                if (v[0] && (!v[1] || m_last)) g = 2'b01;
                else if (v[1]) g = 2'b10;
            end
            ev = (m_busy && m_wait == 0) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", rdy, g);
            chk("rsp_valid", rv, ev);
            if (ev != 0) begin
                chk("rsp_result", m_own ? res1 : res0, m_rsp.res);
                chk("rsp_zero", rz[m_own], m_rsp.z);
                chk("rsp_err", re[m_own], m_rsp.e);
            end
            chk("alu_regs", {alu_data1, alu_data2}, {e_d1, e_d2});
            chk("alu_ctl", {alu_operation, alu_aluop}, {e_op, e_aop});
            if (m_busy && m_wait == 0) begin
                if (rr[m_own]) m_busy = 0;
            end else if (m_busy) m_wait--;
            if (g != 0) begin
                m_own = g[1]; m_last = g[1]; m_busy = 1;
                m_wait = exec_len(op[m_own]);
                m_rsp = golden(op[m_own], aop[m_own], a[m_own], b[m_own]);
                e_d1 = a[m_own]; e_d2 = b[m_own]; e_op = op[m_own]; e_aop = aop[m_own];
            end
        end
    end

    task automatic run_op(input int n, input logic [5:0] o, input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output logic z, output logic e, output int lat);
        int t;
        op[n] = o; aop[n] = m; a[n] = x; b[n] = y; v[n] = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (rdy[n] || t >= 50) break;
            t++;
        end
        chk("hs_in_time", t < 50, 1);
        @(posedge clk); #1 v[n] = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (rv[n] || lat >= 20) break;
            lat++;
        end
        chk("rsp_in_time", lat < 20, 1);
        res = n ? res1 : res0; z = rz[n]; e = re[n];
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] r;
        logic z, e;
        int l, k;
        int gc[4], gn[4];
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // contention from reset: requester 0 first, then strict alternation
        op[0] = 6'd2; a[0] = 9; b[0] = 9;
        op[1] = 6'd5; a[1] = 1; b[1] = 2;
        v = 2'b11; k = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rdy != 0 && k < 4) begin gc[k] = c; gn[k] = int'(rdy[1]); k++; end
        end
        @(posedge clk); #1 v = 2'b00;
        chk("grant_count", k, 4);
        for (int i = 0; i < 4; i++) begin
            chk("grant_cycle", gc[i], 3 * i);
            chk("grant_who", gn[i], i % 2);
        end
        // add with immediate consumption, latency 2
        run_op(0, 6'd1, 2'b00, 5, 3, r, z, e, l);
        chk("add_res", r, 8); chk("add_zero", z, 0); chk("add_err", e, 0); chk("add_lat", l, 2);
        // held response while requester 1 waits
        rr[0] = 1'b0;
        run_op(0, 6'd1, 2'b00, 5, 3, r, z, e, l);
        op[1] = 6'd1; aop[1] = 2'b00; a[1] = 1; b[1] = 1; v[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rdy1", rdy[1], 0); chk("stall_vld0", rv[0], 1); chk("stall_res0", res0, 8);
        end
        @(posedge clk); #1 rr[0] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk); chk("req1_after_stall", rdy[1], 1);
        @(posedge clk); #1 v[1] = 1'b0;
        repeat (4) @(posedge clk); #1;
        // undefined cases
        run_op(0, 6'd10, 2'b00, 10, 0, r, z, e, l);
        chk("div0_err", e, 1); chk("div0_res", r, 0);
        run_op(1, 6'd11, 2'b00, 10, 3, r, z, e, l);
        chk("mod_res", r, 1); chk("mod_err", e, 0);
        run_op(0, 6'd63, 2'b00, 1, 2, r, z, e, l);
        chk("illegal_err", e, 1); chk("illegal_res", r, 0);
        run_op(0, 6'd2, 2'b10, 4, 4, r, z, e, l);
        chk("bne_eq_zero", z, 0); chk("bne_eq_res", r, 0);
        run_op(0, 6'd2, 2'b10, 4, 5, r, z, e, l);
        chk("bne_ne_zero", z, 1);
        run_op(1, 6'd1, 2'b01, 7, 9, r, z, e, l);
        chk("imm_res", r, 9); chk("imm_zero", z, 0);
        // reset during EXEC drops the op
        op[0] = 6'd1; aop[0] = 2'b00; a[0] = 5; b[0] = 6; v[0] = 1'b1;
        @(negedge clk); chk("pre_rst_ready", rdy[0], 1);
        @(posedge clk); #1 v[0] = 1'b0; rst_n = 1'b0;
        #1;
        chk("rst_async_ctl", {rdy, rv, re, rz, alu_operation, alu_aluop}, 0);
        chk("rst_async_alu", {alu_data1, alu_data2}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_op(1, 6'd1, 2'b00, 2, 2, r, z, e, l);
        chk("post_rst_res", r, 4); chk("post_rst_lat", l, 2);
        op[1] = 6'd3; a[1] = 6; b[1] = 3; v = 2'b11;
        @(negedge clk); chk("post_rst_winner", rdy, 2'b01);
        @(posedge clk); #1 v = 2'b00;
        repeat (4) @(posedge clk); #1;
        // multiply; stretched when the multicycle option is built in
        run_op(0, 6'd9, 2'b00, 6, 7, r, z, e, l);
        chk("mul_res", r, 42);
`ifdef ALU_SHARE_MULTICYCLE_EN
        chk("mul_lat", l, 2 + LAT);
`else
        chk("mul_lat", l, 2);
`endif
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Controller that time-shares the single combinational ALU between two requesters: requester 0 is the main execute stage, requester 1 is the address/branch-compare unit. It performs round-robin arbitration with valid/ready handshakes and registers the operands that drive the ALU. It captures the ALU result and zero flag and returns them on a held response channel. It also defines the ALU's unspecified cases: undefined op codes, divide/modulo by zero, and the branch-compare/immediate-pass modes that drive only one ALU output.

Parameters:
DATA_W, 32, operand/result width (ALU is 32-bit; other values are for bench use only)
MULDIV_LAT, 4, extra EXEC cycles for op codes 6'b001001..6'b001011 when ALU_SHARE_MULTICYCLE_EN is defined

Ports:
clk  in  1  clock; single clock domain
rst_n  in  1  asynchronous, active-low reset
reqN_valid  in  1 (N=0,1)  request valid
reqN_ready  out  1 (N=0,1)  request accepted this cycle when valid&ready
reqN_op  in  6 (N=0,1)  ALU operation code, 6'b000000..6'b001011 legal
reqN_aluop  in  2 (N=0,1)  ALUOp mode: 00 normal/BEQ, 01 and 11 immediate pass, 10 BNE
reqN_a / reqN_b  in  DATA_W (N=0,1)  operands data1/data2
rspN_valid  out  1 (N=0,1)  response valid
rspN_ready  in  1 (N=0,1)  response consumed when valid&ready
rspN_result  out  DATA_W (N=0,1)  captured result
rspN_zero  out  1 (N=0,1)  captured zero/compare flag
rspN_err  out  1 (N=0,1)  illegal op code, or divide/modulo by zero
alu_data1 / alu_data2  out  DATA_W  to ALU operands (registered)
alu_operation  out  6  to ALU operation (registered)
alu_aluop  out  2  to ALU ALUOp (registered)
alu_result  in  DATA_W  from ALU aluResult
alu_zero  in  1  from ALU zero

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; operand and result registers 0; last_grant=1, so requester 0 wins first. Reset asserted mid-operation drops the in-flight op with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant = the only valid requester; if both are valid, the requester not equal to last_grant. reqN_ready=1 combinationally for the granted requester only, 0 for the other.
- On handshake: latch op, aluop, a and b into the alu_* registers; record owner; last_grant<=owner; go to EXEC.
- EXEC: 1 cycle (no macro). At the end of EXEC, capture into the owner's rsp registers:
  - result = alu_result, except 0 when aluop=10, when op is illegal, or when op is div/mod with b==0.
  - zero = alu_zero when aluop is 00 or 10; otherwise 0.
  - err = (op>6'b001011) | ((op==6'b001010 | op==6'b001011) & b==0).
  - Then go to RESP.
- RESP: rspN_valid=1 for the owner only. result, zero and err stay stable until rspN_ready. On handshake: clear rspN_valid and go to IDLE. All reqN_ready stay 0 in EXEC and RESP.
- Latency: response valid 2 cycles after the request handshake. Maximum throughput is one op per 3 cycles; a same-cycle rsp_ready still costs the IDLE cycle.
- Requesters must hold valid and payload until ready. A requester that deasserts valid without a handshake is not granted.
- alu_* outputs keep the last issued values between operations. No combinational path from reqN_* to alu_*.

Optional Feature:
ALU_SHARE_MULTICYCLE_EN:
- Defined: for op codes 001001, 001010 and 001011, EXEC lasts 1+MULDIV_LAT cycles, counted by a down-counter loaded at the handshake. Capture happens in the final EXEC cycle. All other ops still take 1 cycle.
- Undefined: no counter; every op takes 1 EXEC cycle.

Decomposition:
- Package alu_pkg holds:
  - op code constants OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_MUL, OP_DIV, OP_MOD, and OP_LAST=6'b001011
  - ALUOp constants AOP_NORM=00, AOP_IMM=01, AOP_BNE=10, AOP_IMM4=11
  - the state enum
- One sub-module: rr_arb2, a 2-way round-robin grant taking valid[1:0] and last_grant and returning grant[1:0].

Test Plan:
- req0 add (op 000001, aluop 00) a=5, b=3 with rsp0_ready=1 -> rsp0_valid exactly 2 cycles after the handshake, result=8, zero=0, err=0.
- req0 and req1 both valid continuously from reset -> grants go 0,1,0,1; each requester sees one response per 6 cycles.
- rsp0_ready held 0 for 5 cycles while req1 is valid -> rsp0 values stay stable, req1_ready stays 0; req1 is granted in the first IDLE after the rsp0 handshake.
- div 10/0 -> err=1, result=0. mod 10/3 -> result=1, err=0. op 6'b111111 -> err=1, result=0.
- aluop 10 (BNE) with a=4, b=4 -> zero=0, result=0. With a=4, b=5 -> zero=1.
- rst_n pulsed low during EXEC -> all outputs 0 immediately; after release, req1 alone completes normally and req0 wins the next contention. With the macro defined, mul 6*7 -> result 42 after 2+MULDIV_LAT cycles.
